stim_seq_nand: RTL

- Stimulus-and-check stage sitting directly upstream of the 2-input NAND cell (ports a[1:0] -> c).
- Drives the NAND's input vector through a programmable sequence, holding each vector for a fixed number of cycles.
- Samples the returned c at the end of each hold window, compares it against the expected ~&a, and counts mismatches.
- Replaces hand-written #delay stimulus with a synthesizable, clocked sequencer.

---
 rtl/stim_pkg.sv | 15 +
 rtl/seq_gen.sv | 22 ++
 rtl/stim_seq_nand.sv | 120 ++++++++++++
 3 files changed

// File: rtl/stim_pkg.sv
// Shared encodings for the NAND stimulus sequencer: sequence modes and FSM states.
// Imported by the sequencer top and the reusable vector generator.
package stim_pkg;

  localparam logic [1:0] MODE_BIN_UP = 2'b00;
  localparam logic [1:0] MODE_GRAY   = 2'b01;
  localparam logic [1:0] MODE_BIN_DN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_gen.sv
// Combinational step/mode -> stimulus vector mapping; zero latency, no flow control.
// Unknown mode (2'b11) falls back to binary up.
module seq_gen
  import stim_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] step,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] vec
);

  always_comb begin
    vec = step;
    case (mode)
      MODE_GRAY:   vec = step ^ (step >> 1);
      MODE_BIN_DN: vec = ~step;
      default:     vec = step;
    endcase
  end

endmodule

// File: rtl/stim_seq_nand.sv
// Clocked stimulus sequencer for a 2-input NAND: steps a through a pattern, checks c
// at the end of each hold window and counts mismatches; first vector appears the cycle after start.
module stim_seq_nand
  import stim_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int STEP_CYCLES = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [3:0]       reps,
  input  logic             c,
  output logic [WIDTH-1:0] a,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [3:0]       HOLD_LAST = 4'(STEP_CYCLES - 1);
  localparam logic [WIDTH-1:0] STEP_LAST = '1;
  localparam logic [WIDTH-1:0] STEP_ONE  = WIDTH'(1);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [3:0]       pass_q, pass_d;
  logic [3:0]       hold_q, hold_d;
  logic [3:0]       reps_q, reps_d;
  logic [1:0]       mode_q, mode_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] seq_vec;

  seq_gen #(.WIDTH(WIDTH)) u_seq_gen (
    .step (step_q),
    .mode (mode_q),
    .vec  (seq_vec)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    pass_d  = pass_q;
    hold_d  = hold_q;
    reps_d  = reps_q;
    mode_d  = mode_q;
    err_d   = err_q;
    a       = '0;
    valid   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          reps_d  = reps;
          step_d  = '0;
          pass_d  = '0;
          hold_d  = '0;
          err_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a     = seq_vec;
        valid = 1'b1;
        busy  = 1'b1;
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          // c is assumed settled by the final cycle of the hold window
          if ((c != ~&seq_vec) && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_ONE;
          end
          if (step_q != STEP_LAST) begin
            step_d = step_q + STEP_ONE;
          end else if (pass_q < reps_q) begin
            pass_d = pass_q + 4'd1;
            step_d = '0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      pass_q  <= '0;
      hold_q  <= '0;
      reps_q  <= '0;
      mode_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      pass_q  <= pass_d;
      hold_q  <= hold_d;
      reps_q  <= reps_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  assign err_cnt = err_q;

endmodule
